// File: rtl/key_event_queue.sv
// -----------------------------------------------------------------------------
// key_event_queue
//
// Collects one-cycle key press pulses from the debounce/edge block. It turns
// them into 2-bit event codes and queues them for the game FSM, which drains
// them through a valid/ready handshake.
//
// Processing happens in two stages:
//   1. A pending register holds one bit per key. A press sets its bit. If the
//      bit is already set and is not being drained that cycle, the press is
//      coalesced and the sticky overflow flag is raised.
//   2. A serializer moves at most one pending key per cycle into a show-ahead
//      FIFO. It uses fixed priority: left > right > up > down. It only does
//      this while the FIFO is not full, judged on the count before the edge.
//
// Parameters
//   DEPTH   FIFO entries, power of two, >= 2
//   ADDR_W  log2(DEPTH)
//
// Ports
//   CLK_50M          in   system clock, all state on the rising edge
//   RSTn             in   asynchronous active-low reset
//   left_key_press   in   one-cycle press pulse, left  (code 0)
//   right_key_press  in   one-cycle press pulse, right (code 1)
//   up_key_press     in   one-cycle press pulse, up    (code 2)
//   down_key_press   in   one-cycle press pulse, down  (code 3)
//   evt_ready        in   consumer accepts the head event this cycle
//   clr_overflow     in   clears the sticky overflow flag
//   evt_valid        out  queue non-empty, evt_code is meaningful
//   evt_code         out  head event code, 0 while empty
//   evt_count        out  entries held, 0..DEPTH
//   overflow         out  sticky: at least one press was coalesced
// -----------------------------------------------------------------------------
module key_event_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK_50M,
    input  logic              RSTn,
    input  logic              left_key_press,
    input  logic              right_key_press,
    input  logic              up_key_press,
    input  logic              down_key_press,
    input  logic              evt_ready,
    input  logic              clr_overflow,
    output logic              evt_valid,
    output logic [1:0]        evt_code,
    output logic [ADDR_W:0]   evt_count,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [3:0]        pending_q, pending_d;
    logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        mem_q [DEPTH];

    // -------------------------------------------------------------------------
    // Combinational control
    // -------------------------------------------------------------------------
    logic [3:0] press_vec;
    logic [3:0] push_onehot;
    logic [3:0] coalesce_vec;
    logic [1:0] push_code;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    assign press_vec  = {down_key_press, up_key_press, right_key_press, left_key_press};
    assign fifo_full  = (count_q == FULL_COUNT);
    assign fifo_empty = (count_q == '0);

    // Fullness is judged on the registered count only. A pop in the same
    // cycle does not open a slot for a push until the next cycle.
    assign push = (pending_q != 4'b0000) && !fifo_full;
    assign pop  = !fifo_empty && evt_ready;

    // Lowest set pending bit wins: left > right > up > down.
    always_comb begin
        push_code = 2'd0;
        casez (pending_q)
            4'b???1: push_code = 2'd0;
            4'b??10: push_code = 2'd1;
            4'b?100: push_code = 2'd2;
            4'b1000: push_code = 2'd3;
            default: push_code = 2'd0;
        endcase
    end

    assign push_onehot = push ? (4'b0001 << push_code) : 4'b0000;

    // Per-key pending update. A new press of the key being drained this
    // cycle re-arms its bit. A press on a bit that stays set is lost.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pending
            assign pending_d[gi]    = press_vec[gi] | (pending_q[gi] & ~push_onehot[gi]);
            assign coalesce_vec[gi] = press_vec[gi] &  pending_q[gi] & ~push_onehot[gi];
        end
    endgenerate

    // Sticky overflow: a coalesce in the same cycle as a clear wins.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (|coalesce_vec) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            pending_q  <= 4'b0000;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset. Stale contents are hidden because the output
    // is gated by count, and count is cleared by reset.
    always_ff @(posedge CLK_50M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (show-ahead head of queue)
    // -------------------------------------------------------------------------
    assign evt_valid = !fifo_empty;
    assign evt_code  = fifo_empty ? 2'd0 : mem_q[rd_ptr_q];
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule
